// File: rtl/video_fetch_pkg.sv
// Shared types and defaults for the framebuffer fetch controller.
// FSM state encoding plus frame-size and byte-index constants.
package video_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    FILL,
    WAIT,
    DRAIN
  } fetch_state_t;

  localparam int FRAME_WORDS_640X480 = 9600;
  localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/video_fetch_fifo.sv
// Show-ahead word FIFO for the fetch controller.
// Head word is visible on rdata whenever the FIFO is non-empty.
module video_fetch_fifo #(
  parameter int LOG2 = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic [31:0]     wdata,
  input  logic            pop,
  output logic [31:0]     rdata,
  output logic [LOG2:0]   level,
  output logic            full,
  output logic            empty
);

  localparam int DEPTH = 2 ** LOG2;
  localparam logic [LOG2:0] DEPTH_LVL = (LOG2 + 1)'(DEPTH);

  logic [31:0]     mem [DEPTH];
  logic [LOG2-1:0] wp;
  logic [LOG2-1:0] rp;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == DEPTH_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wp] <= wdata;
  end

endmodule

// File: rtl/video_fetch_ctrl.sv
// Framebuffer fetch controller: watermark-driven word fetch, byte unpack.
// Optional saturating underflow counter: VIDEO_FETCH_UNDERFLOW_CNT_EN.
module video_fetch_ctrl
  import video_fetch_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int FIFO_LOG2   = 4,
  parameter int LOW_WM      = 4,
  parameter int FRAME_WORDS = FRAME_WORDS_640X480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              vsync_n,
  input  logic              rd,
  output logic [7:0]        disp_data,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [31:0]       bus_data,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int LEFT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [LEFT_W-1:0] FRAME_CNT = LEFT_W'(FRAME_WORDS);
  localparam logic [FIFO_LOG2:0] DEPTH_LVL = (FIFO_LOG2 + 1)'(2 ** FIFO_LOG2);
  localparam logic [FIFO_LOG2:0] LOW_LVL = (FIFO_LOG2 + 1)'(LOW_WM);

  fetch_state_t          state;
  logic [ADDR_W-1:0]     ptr;
  logic [LEFT_W-1:0]     left;
  logic                  fetching;
  logic [BYTE_IDX_W-1:0] idx;
  logic                  vs_m, vs_s, vs_d;
  logic                  restart;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  rd_ok;
  logic                  go;
  logic [31:0]           head;
  logic [FIFO_LOG2:0]    level;
  logic                  full;
  logic                  empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_m <= 1'b1;
      vs_s <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      vs_m <= vsync_n;
      vs_s <= vs_m;
      vs_d <= vs_s;
    end
  end

  assign restart = vs_d & ~vs_s;
  assign flush   = (state == FLUSH);
  assign push    = (state == WAIT) & bus_ack & ~restart;
  assign rd_ok   = rd & ~restart & ~flush;
  assign pop     = rd_ok & ~empty & (idx == '1);
  assign go      = ~full & (fetching | (level < LOW_LVL));

  video_fetch_fifo #(
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .wdata (bus_data),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      left     <= '0;
      bus_req  <= 1'b0;
      bus_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (restart)
            state <= FLUSH;
        end
        FLUSH: begin
          ptr   <= base_addr;
          left  <= FRAME_CNT;
          state <= restart ? FLUSH : FILL;
        end
        FILL: begin
          if (restart) begin
            state <= FLUSH;
          end else if (left != '0 && go) begin
            bus_req  <= 1'b1;
            bus_addr <= ptr;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (restart) begin
              state <= FLUSH;
            end else begin
              ptr   <= ptr + 1'b1;
              left  <= left - 1'b1;
              state <= FILL;
            end
          end else if (restart) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // the outstanding read must complete before the bus is reusable
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= FLUSH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetching <= 1'b0;
    else if (flush)
      fetching <= 1'b0;
    else if (push && !pop && level == DEPTH_LVL - 1'b1)
      fetching <= 1'b0;
    else if (level < LOW_LVL)
      fetching <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      idx       <= '0;
      underflow <= 1'b0;
    end else if (rd_ok) begin
      if (empty)
        underflow <= 1'b1;
      else
        idx <= idx + 1'b1;
    end
  end

  always_comb begin
    disp_data = 8'h00;
    if (!empty)
      disp_data = head[{idx, 3'b000} +: 8];
  end

`ifdef VIDEO_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ucnt <= '0;
    else if (rd_ok && empty && ucnt != 16'hFFFF)
      ucnt <= ucnt + 1'b1;
  end

  assign underflow_cnt = ucnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// Directed bench for video_fetch_ctrl with a small acking bus model.
// Build with VIDEO_FETCH_UNDERFLOW_CNT_EN to expect a live counter.
module tb_video_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync_n = 1'b1;
  logic        rd = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_data = '0;
  logic [29:0] base_addr = 30'h1000;
  logic [29:0] bus_addr;
  logic        bus_req;
  logic        underflow;
  logic [7:0]  disp_data;
  logic [15:0] underflow_cnt;
  logic        ack_hold = 1'b0;
  logic [29:0] addr_q [$];
  int          checks = 0;
  int          errors = 0;

`ifdef VIDEO_FETCH_UNDERFLOW_CNT_EN
  localparam logic [15:0] UCNT_EXP = 16'd3;
`else
  localparam logic [15:0] UCNT_EXP = 16'd0;
`endif

  video_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .base_addr     (base_addr),
    .vsync_n       (vsync_n),
    .rd            (rd),
    .disp_data     (disp_data),
    .bus_req       (bus_req),
    .bus_addr      (bus_addr),
    .bus_ack       (bus_ack),
    .bus_data      (bus_data),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return 32'h44332211 + {2'b00, a} - 32'h1000;
  endfunction

  // zero-wait memory: acks in the first cycle bus_req is seen high
  always begin
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    if (bus_req && !ack_hold && !reset) begin
      bus_ack  = 1'b1;
      bus_data = word_of(bus_addr);
      addr_q.push_back(bus_addr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic vsync_fall();
    @(negedge clk);
    vsync_n = 1'b0;
    repeat (4) @(negedge clk);
    vsync_n = 1'b1;
  endtask

  task automatic pulse_rd(input int n);
    repeat (n) begin
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: got %b want 0", bus_req);
    end
    checks++;
    if (bus_addr !== 30'h0) begin
      errors++;
      $display("FAIL rst_addr: got %h want 0", bus_addr);
    end
    checks++;
    if (disp_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_disp: got %h want 00", disp_data);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_uf: got %b want 0", underflow);
    end
    checks++;
    if (underflow_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rst_ucnt: got %h want 0", underflow_cnt);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (addr_q.size() !== 0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d reqs want 0", addr_q.size());
    end
  endtask

  task automatic test_fill();
    int seq_err = 0;
    base_addr = 30'h1000;
    addr_q.delete();
    @(negedge clk);
    vsync_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL req_early: got %b want 0", bus_req);
    end
    @(negedge clk);
    vsync_n = 1'b1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 30'h1000) begin
      errors++;
      $display("FAIL req_first: got %b/%h want 1/1000", bus_req, bus_addr);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (addr_q.size() !== 16) begin
      errors++;
      $display("FAIL fill_count: got %0d want 16", addr_q.size());
    end
    foreach (addr_q[i])
      if (addr_q[i] !== 30'h1000 + 30'(i))
        seq_err++;
    checks++;
    if (seq_err !== 0) begin
      errors++;
      $display("FAIL fill_seq: got %0d bad addrs want 0", seq_err);
    end
    checks++;
    if (bus_req !== 1'b0 || dut.u_fifo.level !== 5'd16) begin
      errors++;
      $display("FAIL fill_stop: got req %b lvl %0d want 0/16",
               bus_req, dut.u_fifo.level);
    end
    checks++;
    if (disp_data !== 8'h11) begin
      errors++;
      $display("FAIL fill_head: got %h want 11", disp_data);
    end
  endtask

  task automatic test_unpack();
    logic [7:0] exp_b [4] = '{8'h22, 8'h33, 8'h44, 8'h12};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        checks++;
        if (dut.u_fifo.level !== 5'd16) begin
          errors++;
          $display("FAIL unpack_lvl3: got %0d want 16", dut.u_fifo.level);
        end
      end
      pulse_rd(1);
      checks++;
      if (disp_data !== exp_b[i]) begin
        errors++;
        $display("FAIL unpack_b%0d: got %h want %h", i, disp_data, exp_b[i]);
      end
    end
    checks++;
    if (dut.u_fifo.level !== 5'd15) begin
      errors++;
      $display("FAIL unpack_pop: got %0d want 15", dut.u_fifo.level);
    end
  endtask

  task automatic test_hysteresis();
    addr_q.delete();
    pulse_rd(44);
    checks++;
    if (addr_q.size() !== 0 || dut.u_fifo.level !== 5'd4) begin
      errors++;
      $display("FAIL hyst_quiet: got %0d reqs lvl %0d want 0/4",
               addr_q.size(), dut.u_fifo.level);
    end
    pulse_rd(4);
    checks++;
    if (bus_req !== 1'b0 || dut.u_fifo.level !== 5'd3) begin
      errors++;
      $display("FAIL hyst_lvl3: got req %b lvl %0d want 0/3",
               bus_req, dut.u_fifo.level);
    end
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 30'h1010) begin
      errors++;
      $display("FAIL hyst_fire: got %b/%h want 1/1010", bus_req, bus_addr);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (addr_q.size() !== 13 || dut.u_fifo.level !== 5'd16) begin
      errors++;
      $display("FAIL hyst_refill: got %0d reqs lvl %0d want 13/16",
               addr_q.size(), dut.u_fifo.level);
    end
  endtask

  task automatic test_drain();
    ack_hold = 1'b1;
    base_addr = 30'h1000;
    addr_q.delete();
    vsync_fall();
    for (int i = 0; i < 10 && bus_req !== 1'b1; i++)
      @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 30'h1000) begin
      errors++;
      $display("FAIL drain_req: got %b/%h want 1/1000", bus_req, bus_addr);
    end
    base_addr = 30'h2000;
    vsync_fall();
    repeat (6) @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 30'h1000) begin
      errors++;
      $display("FAIL drain_hold: got %b/%h want 1/1000", bus_req, bus_addr);
    end
    ack_hold = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (addr_q.size() !== 17) begin
      errors++;
      $display("FAIL drain_count: got %0d want 17", addr_q.size());
    end
    checks++;
    if (addr_q.size() < 17 || addr_q[0] !== 30'h1000 ||
        addr_q[1] !== 30'h2000 || addr_q[16] !== 30'h200F) begin
      errors++;
      $display("FAIL drain_addr: got %0d entries, want 1000,2000..200F",
               addr_q.size());
    end
    checks++;
    if (dut.u_fifo.level !== 5'd16) begin
      errors++;
      $display("FAIL drain_lvl: got %0d want 16", dut.u_fifo.level);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulse_rd(3);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_flag: got %b want 1", underflow);
    end
    checks++;
    if (underflow_cnt !== UCNT_EXP) begin
      errors++;
      $display("FAIL uf_cnt: got %0d want %0d", underflow_cnt, UCNT_EXP);
    end
    checks++;
    if (disp_data !== 8'h00) begin
      errors++;
      $display("FAIL uf_disp: got %h want 00", disp_data);
    end
    base_addr = 30'h2000;
    vsync_fall();
    repeat (20) @(negedge clk);
    checks++;
    if (underflow !== 1'b0 || underflow_cnt !== UCNT_EXP) begin
      errors++;
      $display("FAIL uf_restart: got %b/%0d want 0/%0d",
               underflow, underflow_cnt, UCNT_EXP);
    end
    checks++;
    if (disp_data !== 8'h11) begin
      errors++;
      $display("FAIL uf_head: got %h want 11", disp_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] first;
    base_addr = 30'h1000;
    vsync_fall();
    repeat (4) @(negedge clk);
    ack_hold = 1'b1;
    for (int i = 0; i < 10 && bus_req !== 1'b1; i++)
      @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || disp_data !== 8'h11) begin
      errors++;
      $display("FAIL mid_pre: got %b/%h want 1/11", bus_req, disp_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_addr !== 30'h0 || disp_data !== 8'h00 ||
        underflow !== 1'b0 || underflow_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst: got %b/%h/%h/%b/%h want 0/0/00/0/0",
               bus_req, bus_addr, disp_data, underflow, underflow_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    ack_hold = 1'b0;
    addr_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (addr_q.size() !== 0) begin
      errors++;
      $display("FAIL mid_quiet: got %0d reqs want 0", addr_q.size());
    end
    vsync_fall();
    repeat (10) @(negedge clk);
    first = (addr_q.size() > 0) ? addr_q[0] : 30'h3FFF_FFFF;
    checks++;
    if (first !== 30'h1000) begin
      errors++;
      $display("FAIL mid_resume: got %h want 1000", first);
    end
  endtask

  task automatic test_frame_end();
    int seq_err = 0;
    logic [29:0] last;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base_addr = 30'h3FFF_FF00;
    addr_q.delete();
    vsync_fall();
    rd = 1'b1;
    for (int i = 0; i < 45000; i++) begin
      @(negedge clk);
      if (addr_q.size() >= 9600)
        break;
    end
    repeat (200) @(negedge clk);
    rd = 1'b0;
    checks++;
    if (addr_q.size() !== 9600 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL frame_count: got %0d req %b want 9600/0",
               addr_q.size(), bus_req);
    end
    foreach (addr_q[i])
      if (addr_q[i] !== 30'h3FFF_FF00 + 30'(i))
        seq_err++;
    checks++;
    if (seq_err !== 0) begin
      errors++;
      $display("FAIL frame_seq: got %0d bad addrs want 0", seq_err);
    end
    last = (addr_q.size() > 0) ? addr_q[addr_q.size() - 1] : 30'h0;
    checks++;
    if (last !== 30'h247F) begin
      errors++;
      $display("FAIL frame_wrap: got %h want 247F", last);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_unpack();
    test_hysteresis();
    test_drain();
    test_underflow();
    test_reset_mid();
    test_frame_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_fetch_ctrl.md
# video_fetch_ctrl

Framebuffer fetch controller for the 640x480 monochrome video output. It sits between the CPU memory bus and the display core. It schedules single-word read requests into a local FIFO using low-watermark hysteresis, unpacks 32-bit words into bytes on each display `rd` pulse, and restarts the frame at the base address on every vertical sync.

## Interface
- `ADDR_W`, 30: word-address width on the memory bus.
- `FIFO_LOG2`, 4: FIFO depth is 2**FIFO_LOG2 words.
- `LOW_WM`, 4: fetching starts when FIFO level < LOW_WM.
- `FRAME_WORDS`, 9600: 32-bit words per frame (640*480/32).

- `clk` in 1: CPU clock; the only clock.
- `reset` in 1: asynchronous, active-high.
- `base_addr` in ADDR_W: framebuffer word address, sampled at frame restart.
- `vsync_n` in 1: display vsync, active low, pixel-clock domain (synchronised internally).
- `rd` in 1: one-`clk` pulse from the display; the current byte has been consumed.
- `disp_data` out 8: current byte for the display.
- `bus_req` out 1: read request.
- `bus_addr` out ADDR_W: request word address.
- `bus_ack` in 1: one-cycle acknowledge; `bus_data` is valid in the same cycle.
- `bus_data` in 32: read data.
- `underflow` out 1: sticky; `rd` arrived with the FIFO empty.
- `underflow_cnt` out 16: saturating underflow count (see Configuration).

## Operation
- `vsync_n` passes through a 2-flop synchroniser plus an edge register. A frame restart is the synchronised falling edge (sync assertion).
- FSM states and transitions:
  - **IDLE**: wait for frame restart.
  - **FLUSH**: clear FIFO, byte index := 0, `ptr` := `base_addr`, `left` := FRAME_WORDS, clear `underflow`. Next state is FILL.
  - **FILL**: if `left` == 0, stay. Otherwise, if `fetching` and FIFO not full, assert `bus_req` with `bus_addr` = `ptr` and go to WAIT.
  - **WAIT**: hold `bus_req` and `bus_addr` stable until `bus_ack`. On ack: push `bus_data`, `ptr` += 1, `left` -= 1, return to FILL.
  - **DRAIN**: entered when a restart occurs in WAIT. Keep the request until `bus_ack`, discard the data, then go to FLUSH.
- A restart in FILL or IDLE goes directly to FLUSH.
- Hysteresis flag `fetching`:
  - Set when level < LOW_WM.
  - Cleared when the FIFO becomes full, counting the word pushed this cycle.
- Byte unpack:
  - `disp_data` = byte[idx] of the FIFO head word (show-ahead). Byte 0 = bits 7:0; LSB byte first.
  - Each `rd` with FIFO non-empty: idx += 1. When idx == 3, idx wraps to 0 and the head word is popped.
- Underflow: an `rd` with the FIFO empty sets `underflow`, leaves idx unchanged, and holds `disp_data` at 0x00.
- Simultaneous push and pop in one cycle: level is unchanged.
- Simultaneous restart and `rd`: the restart wins and `rd` is ignored.
- Simultaneous restart and `bus_ack` in WAIT: the acked data is discarded and the FSM goes to FLUSH.
- `ptr` wraps modulo 2**ADDR_W. `left` never underflows; at 0, no more requests are issued in the frame.

## Timing
- Reset values: `bus_req`=0, `bus_addr`=0, `disp_data`=0x00, `underflow`=0, `underflow_cnt`=0. FSM=IDLE, FIFO empty.
- Reset asserted mid-WAIT drops `bus_req` immediately.
- The restart edge reaches the FSM 3 `clk` after `vsync_n` falls.
- First `bus_req`: 2 `clk` after the restart (FLUSH, then FILL registers the request).
- `bus_req` is registered and rises the cycle after the FILL decision. After an ack, the next request comes no earlier than 1 cycle later, so peak rate is 1 word / 2 clk.
- Push latency: `bus_data` is written on the `bus_ack` edge. `disp_data` is valid the following cycle when the FIFO was empty.
- `disp_data` changes the cycle after `rd`. The display samples it within its synchroniser window, so `clk` ≥ 4x pixel clock is required.

## Configuration
- `VIDEO_FETCH_UNDERFLOW_CNT_EN` defined:
  - `underflow_cnt` increments on every underflow `rd` and saturates at 0xFFFF.
  - It is cleared only by `reset`, not by frame restart.
- Undefined: `underflow_cnt` is tied to 0 and no counter flops are built. The sticky `underflow` bit exists in both builds.

## Structure
- Package `video_fetch_pkg` holds:
  - the FSM state enum (IDLE, FLUSH, FILL, WAIT, DRAIN);
  - default constants FRAME_WORDS_640X480 = 9600 and BYTE_IDX_W = 2.
- Sub-module `video_fetch_fifo`: synchronous show-ahead FIFO, 32-bit wide, with `clear`, `push`, `pop`, `level`, `full` and `empty`. The FSM, watermark logic, unpacker and synchroniser stay in the top module.

## Test plan
- Restart with `base_addr`=0x1000 and a zero-wait-state bus acking the cycle after `bus_req`: expect addresses 0x1000, 0x1001, ... Requests stop when 16 words are buffered and stop for the frame after exactly 9600 requests.
- Push word 0x44332211, then 4 `rd` pulses: `disp_data` = 0x11, 0x22, 0x33, 0x44. FIFO level decrements by 1 after the 4th `rd`.
- Drain the FIFO from full to 3 words with `rd` only: the first request fires when level hits 3, and fetching continues until full (hysteresis).
- Restart while in WAIT with `bus_ack` delayed 5 cycles: `bus_req` stays high until ack, the data is not pushed, then addresses restart at `base_addr`.
- `rd` with the FIFO empty, 3 times: `underflow`=1. `underflow_cnt`=3 with the macro and 0 without; `disp_data`=0x00.
- Assert `reset` mid-frame: all outputs return to their reset values in the same cycle, and no request is issued until the next `vsync_n` falling edge.
